// File: rtl/shift_arb_pkg.sv
// rtl/shift_arb_pkg.sv - shared ALU types for the shift arbiter and shift unit
package shift_arb_pkg;

  localparam int REQ_ID_W = 1;
  localparam int DATA_W   = 32;
  localparam int SHAMT_W  = $clog2(DATA_W);

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] shamt;
    logic               shope;
  } shift_req_t;

  typedef enum logic {
    SH_RIGHT = 1'b0,
    SH_LEFT  = 1'b1
  } shift_dir_e;

endpackage

// File: rtl/shift.sv
// rtl/shift.sv - combinational logical left/right shifter, zero fill
module shift
  import shift_arb_pkg::*;
#(
  parameter  int WIDTH       = 32,
  localparam int SHAMT_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]       data,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic                   shope,
  output logic [WIDTH-1:0]       result
);

  // Out-of-range amounts only exist when WIDTH is not a power of two.
  always_comb begin
    result = '0;
    if ({1'b0, shamt} < (SHAMT_WIDTH + 1)'(WIDTH)) begin
      if (shift_dir_e'(shope) == SH_LEFT) begin
        result = data << shamt;
      end else begin
        result = data >> shamt;
      end
    end
  end

endmodule

// File: rtl/shift_arb.sv
// rtl/shift_arb.sv - round-robin two-port arbiter sharing one shift unit
module shift_arb
  import shift_arb_pkg::*;
#(
  parameter  int WIDTH       = 32,
  localparam int SHAMT_WIDTH = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [WIDTH-1:0]       req0_data,
  input  logic [SHAMT_WIDTH-1:0] req0_shamt,
  input  logic                   req0_shope,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [WIDTH-1:0]       req1_data,
  input  logic [SHAMT_WIDTH-1:0] req1_shamt,
  input  logic                   req1_shope,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_id
);

  logic                   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]       rsp_data_q, rsp_data_d;
  logic [REQ_ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [REQ_ID_W-1:0]    rr_last_q, rr_last_d;

  logic                   slot_free;
  logic                   any_valid;
  logic [REQ_ID_W-1:0]    grant_id;
  logic                   xfer;
  logic [WIDTH-1:0]       sel_data;
  logic [SHAMT_WIDTH-1:0] sel_shamt;
  logic                   sel_shope;
  logic [WIDTH-1:0]       shift_result;

  // The output register may be refilled in the same cycle it drains.
  assign slot_free = !rsp_valid_q || rsp_ready;
  assign any_valid = req0_valid || req1_valid;
  assign xfer      = slot_free && any_valid;

  always_comb begin
    grant_id = '0;
    if (req0_valid && req1_valid) begin
      grant_id = ~rr_last_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign req0_ready = slot_free && req0_valid && (grant_id == 1'b0);
  assign req1_ready = slot_free && req1_valid && (grant_id == 1'b1);

  always_comb begin
    sel_data  = req0_data;
    sel_shamt = req0_shamt;
    sel_shope = req0_shope;
    if (grant_id == 1'b1) begin
      sel_data  = req1_data;
      sel_shamt = req1_shamt;
      sel_shope = req1_shope;
    end
  end

  shift #(
    .WIDTH(WIDTH)
  ) u_shift (
    .data  (sel_data),
    .shamt (sel_shamt),
    .shope (sel_shope),
    .result(shift_result)
  );

  // Data and id deliberately hold after a drain; only valid clears.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rr_last_d   = rr_last_q;
    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = shift_result;
      rsp_id_d    = grant_id;
      rr_last_d   = grant_id;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rr_last_q   <= 1'b1;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rr_last_q   <= rr_last_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: doc/shift_arb.md
Name: shift_arb

Overview:
- Two-port arbiter and sequencer that shares one instance of the team's `shift` datapath between two requesters, such as two issue slots of the ALU.
- Each requester presents a shift operation over a valid/ready handshake. A round-robin grant selects one per cycle.
- The result is captured in a single output register and returned over a valid/ready response channel, tagged with the requester ID.

Parameters:
- WIDTH, 32, data width of operands and results.
- SHAMT_WIDTH, $clog2(WIDTH), shift-amount width; derived, never overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_data  input  WIDTH  requester 0 operand.
- req0_shamt  input  SHAMT_WIDTH  requester 0 shift amount.
- req0_shope  input  1  requester 0 direction: 1 = left logical, 0 = right logical.
- req1_valid, req1_ready, req1_data, req1_shamt, req1_shope: same as requester 0, for requester 1.
- rsp_valid  output  1  result register holds a valid result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  WIDTH  shifted result.
- rsp_id  output  1  ID of the requester that produced rsp_data.

Behaviour:
- Reset (async assert, sync release):
  - rsp_valid=0, rsp_data=0, rsp_id=0.
  - Round-robin pointer rr_last=1, so requester 0 has priority on the first contention.
- Slot free: slot_free = !rsp_valid || rsp_ready (pass-through drain; full throughput of 1 op/cycle).
- Grant (combinational):
  - Only one valid: that one is granted.
  - Both valid: grant = !rr_last.
  - Neither valid: no grant.
- Ready:
  - reqN_ready = slot_free && grant==N && reqN_valid.
  - Ready never depends on reqN_valid of the *other* port except via the grant.
  - At most one ready is high per cycle.
- Transfer: a request transfers when reqN_valid && reqN_ready.
- On a transfer:
  - The mux feeds the selected data/shamt/shope to the shift sub-module.
  - Next edge: rsp_data <= shift result, rsp_id <= N, rsp_valid <= 1, rr_last <= N.
- No transfer: rr_last holds. If rsp_valid && rsp_ready, rsp_valid <= 0. rsp_data and rsp_id hold their last values (no clear).
- Stall: while rsp_valid && !rsp_ready, rsp_data, rsp_id and rsp_valid are stable, and both readys are 0.
- Latency: exactly 1 cycle from request transfer to rsp_valid.
- Requester obligation: valid and payload are held until ready. A requester not granted keeps its request; the arbiter has no request buffering.
- Starvation bound: with both ports continuously valid and rsp_ready=1, grants strictly alternate 0,1,0,1…
- Arithmetic:
  - Left shift: zero-fill from the LSB. Right shift: zero-fill from the MSB.
  - shamt=0 passes data unchanged.
  - If WIDTH is not a power of two and shamt >= WIDTH, the result is 0.
- Reset mid-operation: an in-flight or stalled result is discarded; rsp_valid drops to 0 immediately on rst_n assertion.
- Simultaneous rsp handshake and new grant in the same cycle: the new result replaces the old one; rsp_valid stays 1.

Decomposition:
- Shared ALU package holds:
  - localparam REQ_ID_W=1;
  - typedef shift_req_t {data[WIDTH-1:0], shamt[SHAMT_WIDTH-1:0], shope};
  - enum shift_dir_e {SH_RIGHT=0, SH_LEFT=1}.
- One sub-module: the existing `shift` unit, instantiated once with WIDTH passed through. Arbitration, mux and output register stay in shift_arb.

Test Plan:
- Single request: after reset, req0 {data=0x0000_00F0, shamt=4, shope=1}, rsp_ready=1.
  - req0_ready=1 in cycle 0.
  - Next cycle: rsp_valid=1, rsp_data=0x0000_0F00, rsp_id=0.
- Contention fairness: both valid continuously, req0={0x8000_0000,31,0}, req1={0x1,31,1}, rsp_ready=1.
  - Grants alternate starting with 0.
  - Responses alternate {0x1,id0}, {0x8000_0000,id1}.
- Backpressure: rsp_ready=0 after the first result 0xFFFF_0000 (req1 {0xFFFF_FFFF,16,1}).
  - rsp_data/rsp_id stable and both readys 0 for 5 cycles.
  - On rsp_ready=1, a pending req0 is granted in the same cycle; the result appears the next cycle.
- Edge shifts:
  - {0xA5A5_A5A5, shamt 0, left} -> 0xA5A5_A5A5.
  - {0xA5A5_A5A5, shamt 31, right} -> 0x1.
- Reset mid-stall: rsp_valid=1, rsp_ready=0, then pulse rst_n low between clock edges.
  - rsp_valid=0 and rsp_data=0 immediately.
  - After release, the first contention grants req0.
- Idle: no valids for 10 cycles.
  - rsp_valid stays 0 after the previous drain; readys stay 0; rr_last is unchanged.
